rob: RTL and testbench



---
 rtl/rob_pkg.sv | 32 +++
 rtl/rob_if.sv | 40 ++++
 rtl/rob.sv | 120 ++++++++++++
 tb/tb_rob.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: entry record and the ROB->RS / ROB->map-table packets.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_pkg;

   localparam int ROB_LEN = 8;
   localparam int XLEN    = 32;
   localparam int TAG_W   = $clog2(ROB_LEN) + 1;

   typedef struct packed {
      logic            valid;
      logic            complete;
      logic [4:0]      dest_reg_idx;
      logic [XLEN-1:0] value;
   } ROB_ENTRY;

   typedef struct packed {
      logic [TAG_W-1:0] rob_entry;
      logic [XLEN-1:0]  rs1_value;
      logic             rs1_value_valid;
      logic [XLEN-1:0]  rs2_value;
      logic             rs2_value_valid;
   } ROB2RS_PACKET;

   typedef struct packed {
      logic             retire_valid;
      logic [TAG_W-1:0] retire_tag;
      logic [4:0]       retire_dest_reg_idx;
      logic [XLEN-1:0]  retire_value;
   } ROB2MT_PACKET;

endpackage

// File: rtl/rob_if.sv
// ROB port bundle: dispatch, CDB, operand lookup and retire; master = ROB side.
// Latency: n/a (wiring only).
// Backpressure: rob_full stalls dispatch; other channels are fire-and-forget.
interface rob_if #(
   parameter int XLEN  = rob_pkg::XLEN,
   parameter int TAG_W = rob_pkg::TAG_W
);
   logic             dispatch_valid;
   logic [4:0]       dispatch_dest_reg_idx;
   logic [TAG_W-1:0] rs1_tag_in;
   logic [TAG_W-1:0] rs2_tag_in;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_value;
   logic             squash;
   logic [TAG_W-1:0] rob_entry;
   logic [XLEN-1:0]  rs1_value;
   logic [XLEN-1:0]  rs2_value;
   logic             rs1_value_valid;
   logic             rs2_value_valid;
   logic             rob_full;
   logic             retire_valid;
   logic [TAG_W-1:0] retire_tag;
   logic [4:0]       retire_dest_reg_idx;
   logic [XLEN-1:0]  retire_value;

   modport master (
      input  dispatch_valid, dispatch_dest_reg_idx, rs1_tag_in, rs2_tag_in,
             cdb_valid, cdb_tag, cdb_value, squash,
      output rob_entry, rs1_value, rs2_value, rs1_value_valid, rs2_value_valid,
             rob_full, retire_valid, retire_tag, retire_dest_reg_idx, retire_value
   );

   modport slave (
      output dispatch_valid, dispatch_dest_reg_idx, rs1_tag_in, rs2_tag_in,
             cdb_valid, cdb_tag, cdb_value, squash,
      input  rob_entry, rs1_value, rs2_value, rs1_value_valid, rs2_value_valid,
             rob_full, retire_valid, retire_tag, retire_dest_reg_idx, retire_value
   );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order tag allocation, CDB capture, operand lookup, in-order retire.
// Latency: tag same cycle; CDB result retirable the cycle after capture. ROB_CDB_FORWARD_EN adds same-cycle CDB bypass on operand reads.
// Backpressure: rob_full drops dispatch; retire is never stalled.
module rob #(
   parameter int ROB_LEN = rob_pkg::ROB_LEN,
   parameter int XLEN    = rob_pkg::XLEN,
   parameter int TAG_W   = $clog2(ROB_LEN) + 1
) (
   input logic   clock,
   input logic   reset,
   rob_if.master io
);
   import rob_pkg::*;

   localparam int PTR_W = $clog2(ROB_LEN);
   localparam int CNT_W = $clog2(ROB_LEN + 1);

   ROB_ENTRY         entries [ROB_LEN];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic             rob_full;
   logic             dispatch_fire;
   logic             retire_fire;
   logic             cdb_hit;
   logic [PTR_W-1:0] cdb_idx;
   ROB2RS_PACKET     rob2rs;
   ROB2MT_PACKET     rob2mt;

   // Tag 0 is the register file; tags beyond ROB_LEN must not alias a slot.
   function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
      return (tag != '0) && (tag <= TAG_W'(ROB_LEN));
   endfunction

   function automatic logic [PTR_W-1:0] tag_idx(input logic [TAG_W-1:0] tag);
      return PTR_W'(tag - TAG_W'(1));
   endfunction

   assign rob_full      = (count == CNT_W'(ROB_LEN));
   assign retire_fire   = entries[head].valid && entries[head].complete;
   assign dispatch_fire = io.dispatch_valid && !rob_full;
   assign cdb_idx       = tag_idx(io.cdb_tag);
   assign cdb_hit       = io.cdb_valid && tag_in_range(io.cdb_tag) && entries[cdb_idx].valid;

   always_comb begin
      rob2rs           = '0;
      rob2rs.rob_entry = TAG_W'(tail) + TAG_W'(1);
      if (tag_in_range(io.rs1_tag_in)) begin
         rob2rs.rs1_value       = entries[tag_idx(io.rs1_tag_in)].value;
         rob2rs.rs1_value_valid = entries[tag_idx(io.rs1_tag_in)].valid &&
                                  entries[tag_idx(io.rs1_tag_in)].complete;
      end
      if (tag_in_range(io.rs2_tag_in)) begin
         rob2rs.rs2_value       = entries[tag_idx(io.rs2_tag_in)].value;
         rob2rs.rs2_value_valid = entries[tag_idx(io.rs2_tag_in)].valid &&
                                  entries[tag_idx(io.rs2_tag_in)].complete;
      end
`ifdef ROB_CDB_FORWARD_EN
      if (io.cdb_valid && io.cdb_tag != '0 && io.cdb_tag == io.rs1_tag_in) begin
         rob2rs.rs1_value       = io.cdb_value;
         rob2rs.rs1_value_valid = 1'b1;
      end
      if (io.cdb_valid && io.cdb_tag != '0 && io.cdb_tag == io.rs2_tag_in) begin
         rob2rs.rs2_value       = io.cdb_value;
         rob2rs.rs2_value_valid = 1'b1;
      end
`endif
      rob2mt = '0;
      if (retire_fire) begin
         rob2mt.retire_valid        = 1'b1;
         rob2mt.retire_tag          = TAG_W'(head) + TAG_W'(1);
         rob2mt.retire_dest_reg_idx = entries[head].dest_reg_idx;
         rob2mt.retire_value        = entries[head].value;
      end
   end

   assign io.rob_full            = rob_full;
   assign io.rob_entry           = rob2rs.rob_entry;
   assign io.rs1_value           = rob2rs.rs1_value;
   assign io.rs1_value_valid     = rob2rs.rs1_value_valid;
   assign io.rs2_value           = rob2rs.rs2_value;
   assign io.rs2_value_valid     = rob2rs.rs2_value_valid;
   assign io.retire_valid        = rob2mt.retire_valid;
   assign io.retire_tag          = rob2mt.retire_tag;
   assign io.retire_dest_reg_idx = rob2mt.retire_dest_reg_idx;
   assign io.retire_value        = rob2mt.retire_value;

   // Squash still lets the head retire this cycle (outputs above are unaffected).
   always_ff @(posedge clock) begin
      if (reset || io.squash) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < ROB_LEN; i++) entries[i] <= '0;
      end else begin
         if (cdb_hit) begin
            entries[cdb_idx].complete <= 1'b1;
            entries[cdb_idx].value    <= io.cdb_value;
         end
         if (retire_fire) begin
            entries[head] <= '0;
            head          <= head + PTR_W'(1);
         end
         if (dispatch_fire) begin
            entries[tail].valid        <= 1'b1;
            entries[tail].complete     <= 1'b0;
            entries[tail].dest_reg_idx <= io.dispatch_dest_reg_idx;
            entries[tail].value        <= '0;
            tail                       <= tail + PTR_W'(1);
         end
         case ({dispatch_fire, retire_fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: allocation, in-order retire, full/wrap, operand read, squash, reset.
// Expected values are hand-computed for ROB_LEN=8.
module tb_rob;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clock = ~clock;

   rob_if rif ();
   rob dut (.clock(clock), .reset(reset), .io(rif));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle();
      rif.dispatch_valid        = 1'b0;
      rif.dispatch_dest_reg_idx = '0;
      rif.rs1_tag_in            = '0;
      rif.rs2_tag_in            = '0;
      rif.cdb_valid             = 1'b0;
      rif.cdb_tag               = '0;
      rif.cdb_value             = '0;
      rif.squash                = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic dispatch(input logic [4:0] dest);
      rif.dispatch_valid        = 1'b1;
      rif.dispatch_dest_reg_idx = dest;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] value);
      rif.cdb_valid = 1'b1;
      rif.cdb_tag   = tag;
      rif.cdb_value = value;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_full", rif.rob_full, 0);
      check("rst_retire_valid", rif.retire_valid, 0);
      check("rst_rob_entry", rif.rob_entry, 1);
      check("rst_rs1_value", rif.rs1_value, 0);
      check("rst_rs1_valid", rif.rs1_value_valid, 0);
      check("rst_rs2_valid", rif.rs2_value_valid, 0);
      check("rst_retire_tag", rif.retire_tag, 0);
      check("rst_retire_value", rif.retire_value, 0);

      // Same-cycle tag, then in-order retire with out-of-order completion
      dispatch(5'd1); #1;
      check("disp1_tag", rif.rob_entry, 1);
      step();
      dispatch(5'd2); #1;
      check("disp2_tag", rif.rob_entry, 2);
      check("disp2_no_retire", rif.retire_valid, 0);
      step();
      idle();
      cdb(4'd2, 32'd7); #1;
      check("cdb2_no_retire", rif.retire_valid, 0);
      step();
      cdb(4'd1, 32'd5); #1;
      check("cdb1_no_retire_same_cycle", rif.retire_valid, 0);
      step();
      idle(); #1;
      check("ret1_valid", rif.retire_valid, 1);
      check("ret1_tag", rif.retire_tag, 1);
      check("ret1_value", rif.retire_value, 5);
      check("ret1_dest", rif.retire_dest_reg_idx, 1);
      step();
      check("ret2_valid", rif.retire_valid, 1);
      check("ret2_tag", rif.retire_tag, 2);
      check("ret2_value", rif.retire_value, 7);
      check("ret2_dest", rif.retire_dest_reg_idx, 2);
      step();
      check("ret_done", rif.retire_valid, 0);
      check("after_ret_tag", rif.rob_entry, 3);

      // Fill to full, dropped 9th dispatch, operand reads, wrap
      do_reset();
      for (int i = 0; i < 8; i++) begin
         dispatch(5'(i + 1)); #1;
         check("fill_tag", rif.rob_entry, 64'(i + 1));
         step();
      end
      idle(); #1;
      check("full_set", rif.rob_full, 1);
      check("full_tag", rif.rob_entry, 1);
      dispatch(5'd31);
      step();
      idle(); #1;
      check("full_drop_full", rif.rob_full, 1);
      check("full_drop_tag", rif.rob_entry, 1);
      cdb(4'd3, 32'd10);
      step();
      idle();
      rif.rs1_tag_in = 4'd3; #1;
      check("rs1_stored_value", rif.rs1_value, 10);
      check("rs1_stored_valid", rif.rs1_value_valid, 1);
      rif.rs2_tag_in = 4'd4;
      cdb(4'd4, 32'd9); #1;
`ifdef ROB_CDB_FORWARD_EN
      check("rs2_fwd_value", rif.rs2_value, 9);
      check("rs2_fwd_valid", rif.rs2_value_valid, 1);
`else
      check("rs2_nofwd_value", rif.rs2_value, 0);
      check("rs2_nofwd_valid", rif.rs2_value_valid, 0);
`endif
      idle();
      cdb(4'd1, 32'd11);
      step();
      idle();
      dispatch(5'd20); #1;
      check("wrap_ret_valid", rif.retire_valid, 1);
      check("wrap_ret_tag", rif.retire_tag, 1);
      check("wrap_ret_value", rif.retire_value, 11);
      check("wrap_ret_dest", rif.retire_dest_reg_idx, 1);
      check("wrap_ret_full", rif.rob_full, 1);
      step();
      idle(); #1;
      check("wrap_after_full", rif.rob_full, 0);
      check("wrap_after_tag", rif.rob_entry, 1);
      check("wrap_head2_incomplete", rif.retire_valid, 0);
      dispatch(5'd21); #1;
      check("wrap_reuse_tag", rif.rob_entry, 1);
      step();
      idle(); #1;
      check("wrap_refull", rif.rob_full, 1);
      check("wrap_next_tag", rif.rob_entry, 2);

      // Squash with concurrent dispatch and CDB
      do_reset();
      for (int i = 0; i < 4; i++) begin
         dispatch(5'(i + 1));
         step();
      end
      idle();
      cdb(4'd1, 32'd42);
      step();
      idle();
      rif.squash = 1'b1;
      dispatch(5'd9);
      cdb(4'd2, 32'd3); #1;
      check("sq_retire_valid", rif.retire_valid, 1);
      check("sq_retire_tag", rif.retire_tag, 1);
      check("sq_retire_value", rif.retire_value, 42);
      check("sq_tag_before", rif.rob_entry, 5);
      step();
      idle();
      rif.rs1_tag_in = 4'd1;
      rif.rs2_tag_in = 4'd2; #1;
      check("sq_after_tag", rif.rob_entry, 1);
      check("sq_after_full", rif.rob_full, 0);
      check("sq_after_retire", rif.retire_valid, 0);
      check("sq_rs1_invalid", rif.rs1_value_valid, 0);
      check("sq_rs2_invalid", rif.rs2_value_valid, 0);

      // Reset mid-operation
      idle();
      dispatch(5'd3);
      step();
      step();
      idle();
      cdb(4'd1, 32'd5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      rif.rs1_tag_in = 4'd1; #1;
      check("midrst_tag", rif.rob_entry, 1);
      check("midrst_retire", rif.retire_valid, 0);
      check("midrst_rs1_valid", rif.rs1_value_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
